// File: rtl/core_io_sched_if.sv
// -----------------------------------------------------------------------------
// core_io_sched_if
// Bundle of the scheduler's stream and core-side signals.
//   master : stream source, cores and sink (drives requests, samples, words)
//   slave  : core_io_sched (drives grants, slot status and the drained stream)
// Signals:
//   req_in, src_data, src_valid, src_ready, in_grant, in_data  - input path
//   out_en, core_out, out_busy, sink_data, sink_src,
//   sink_valid, sink_ready, ovf                                - output path
// -----------------------------------------------------------------------------
interface core_io_sched_if #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 32
);
    localparam int SRC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic [N_CORES-1:0]        req_in;
    logic [DATA_W-1:0]         src_data;
    logic                      src_valid;
    logic                      src_ready;
    logic [N_CORES-1:0]        in_grant;
    logic [DATA_W-1:0]         in_data;
    logic [N_CORES-1:0]        out_en;
    logic [N_CORES*DATA_W-1:0] core_out;
    logic [N_CORES-1:0]        out_busy;
    logic [DATA_W-1:0]         sink_data;
    logic [SRC_W-1:0]          sink_src;
    logic                      sink_valid;
    logic                      sink_ready;
    logic                      ovf;

    modport master (
        output req_in, src_data, src_valid, out_en, core_out, sink_ready,
        input  src_ready, in_grant, in_data, out_busy, sink_data, sink_src,
               sink_valid, ovf
    );

    modport slave (
        input  req_in, src_data, src_valid, out_en, core_out, sink_ready,
        output src_ready, in_grant, in_data, out_busy, sink_data, sink_src,
               sink_valid, ovf
    );
endinterface

// File: rtl/core_io_sched.sv
// -----------------------------------------------------------------------------
// core_io_sched
// Shared-I/O scheduler for the core array. Hands each input sample to exactly
// one requesting core (round-robin) and drains per-core output holding slots
// onto a single output stream (round-robin).
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - core_io_sched_if.slave (request/grant input path, slot/sink
//            output path, sticky overflow flag)
// -----------------------------------------------------------------------------
module core_io_sched #(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    core_io_sched_if.slave  bus
);
    localparam int SRC_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam logic [SRC_W-1:0] PTR_RST = SRC_W'(N_CORES - 1);

    // First set bit of mask searching upward from ptr+1, wrapping. Iterating
    // from the farthest candidate down lets the nearest one win last.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [N_CORES-1:0] mask,
                                                 input logic [SRC_W-1:0]   ptr);
        logic [SRC_W-1:0] sel;
        logic [SRC_W-1:0] cand;
        sel = ptr;
        for (int k = N_CORES; k >= 1; k--) begin
            cand = SRC_W'((int'(ptr) + k) % N_CORES);
            if (mask[cand]) sel = cand;
        end
        return sel;
    endfunction

    logic [N_CORES-1:0] in_grant_q, in_grant_d;
    logic [DATA_W-1:0]  in_data_q, in_data_d;
    logic [SRC_W-1:0]   in_ptr_q, in_ptr_d;
    logic [N_CORES-1:0] full_q, full_d;
    logic [DATA_W-1:0]  slot_q [N_CORES];
    logic [DATA_W-1:0]  slot_d [N_CORES];
    logic [DATA_W-1:0]  sink_data_q, sink_data_d;
    logic [SRC_W-1:0]   sink_src_q, sink_src_d;
    logic               sink_valid_q, sink_valid_d;
    logic [SRC_W-1:0]   out_ptr_q, out_ptr_d;
    logic               ovf_q, ovf_d;

    logic [N_CORES-1:0] req_eff;
    logic [N_CORES-1:0] drain_mask;
    logic               src_xfer;
    logic               drain_go;
    logic [SRC_W-1:0]   in_win;
    logic [SRC_W-1:0]   out_win;

    // A core granted last cycle is masked so it has time to drop its request.
    assign req_eff       = bus.req_in & ~in_grant_q;
    assign bus.src_ready = rst_n & (|req_eff);
    assign src_xfer      = bus.src_valid & bus.src_ready;
    assign in_win        = rr_pick(req_eff, in_ptr_q);
    assign out_win       = rr_pick(full_q, out_ptr_q);
    assign drain_go      = (~sink_valid_q | bus.sink_ready) & (|full_q);

    always_comb begin
        in_grant_d = '0;
        in_data_d  = in_data_q;
        in_ptr_d   = in_ptr_q;
        if (src_xfer) begin
            in_grant_d[in_win] = 1'b1;
            in_data_d          = bus.src_data;
            in_ptr_d           = in_win;
        end
    end

    always_comb begin
        drain_mask = '0;
        if (drain_go) drain_mask[out_win] = 1'b1;

        full_d = full_q;
        slot_d = slot_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < N_CORES; i++) begin
            if (bus.out_en[i]) begin
                // A slot being drained this cycle can take a new word.
                if (!full_q[i] || drain_mask[i]) begin
                    slot_d[i] = bus.core_out[i*DATA_W +: DATA_W];
                    full_d[i] = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (drain_mask[i]) begin
                full_d[i] = 1'b0;
            end
        end

        sink_data_d  = sink_data_q;
        sink_src_d   = sink_src_q;
        sink_valid_d = sink_valid_q;
        out_ptr_d    = out_ptr_q;
        if (drain_go) begin
            sink_data_d  = slot_q[out_win];
            sink_src_d   = out_win;
            sink_valid_d = 1'b1;
            out_ptr_d    = out_win;
        end else if (bus.sink_ready) begin
            sink_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_grant_q   <= '0;
            in_data_q    <= '0;
            in_ptr_q     <= PTR_RST;
            full_q       <= '0;
            slot_q       <= '{default: '0};
            sink_data_q  <= '0;
            sink_src_q   <= '0;
            sink_valid_q <= 1'b0;
            out_ptr_q    <= PTR_RST;
            ovf_q        <= 1'b0;
        end else begin
            in_grant_q   <= in_grant_d;
            in_data_q    <= in_data_d;
            in_ptr_q     <= in_ptr_d;
            full_q       <= full_d;
            slot_q       <= slot_d;
            sink_data_q  <= sink_data_d;
            sink_src_q   <= sink_src_d;
            sink_valid_q <= sink_valid_d;
            out_ptr_q    <= out_ptr_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.in_grant   = in_grant_q;
    assign bus.in_data    = in_data_q;
    assign bus.out_busy   = full_q;
    assign bus.sink_data  = sink_data_q;
    assign bus.sink_src   = sink_src_q;
    assign bus.sink_valid = sink_valid_q;
    assign bus.ovf        = ovf_q;
endmodule

// File: tb/tb_core_io_sched.sv
// -----------------------------------------------------------------------------
// tb_core_io_sched
// Self-checking bench for core_io_sched (N_CORES = 4, DATA_W = 32).
// Expected grants and drained words are queued when stimulus is applied and
// compared by a negedge monitor when the DUT presents them.
// -----------------------------------------------------------------------------
module tb_core_io_sched;
    localparam int N_CORES = 4;
    localparam int DATA_W  = 32;

    typedef struct {
        logic [3:0]  grant;
        logic [31:0] data;
    } in_exp_t;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] data;
    } out_exp_t;

    logic clk;
    logic rst_n;

    core_io_sched_if #(.N_CORES(N_CORES), .DATA_W(DATA_W)) bus ();

    core_io_sched #(.N_CORES(N_CORES), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    in_exp_t  in_q[$];
    out_exp_t out_q[$];
    in_exp_t  mon_in_e;
    out_exp_t mon_out_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [31:0] v);
        bus.core_out[i*DATA_W +: DATA_W] = v;
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_grant != '0) begin
                if (in_q.size() == 0) begin
                    chk("in_extra", 32'(bus.in_grant), 32'd0);
                end else begin
                    mon_in_e = in_q.pop_front();
                    chk("in_grant", 32'(bus.in_grant), 32'(mon_in_e.grant));
                    chk("in_data", bus.in_data, mon_in_e.data);
                end
            end
            if (bus.sink_valid) begin
                if (out_q.size() == 0) begin
                    chk("sink_extra", 32'(bus.sink_valid), 32'd0);
                end else begin
                    mon_out_e = out_q[0];
                    chk("sink_data", bus.sink_data, mon_out_e.data);
                    chk("sink_src", 32'(bus.sink_src), 32'(mon_out_e.src));
                    if (bus.sink_ready) void'(out_q.pop_front());
                end
            end
        end
    end

    logic [3:0] rr_exp [5];
    logic       exp_rdy;

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n          = 1'b0;
        bus.req_in     = 4'b1111;
        bus.src_valid  = 1'b1;
        bus.src_data   = 32'd10;
        bus.out_en     = '0;
        bus.core_out   = '0;
        bus.sink_ready = 1'b0;

        // Reset: source held valid must not be acknowledged.
        tick(2);
        chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
        chk("rst_in_grant", 32'(bus.in_grant), 32'd0);
        chk("rst_in_data", bus.in_data, 32'd0);
        chk("rst_out_busy", 32'(bus.out_busy), 32'd0);
        chk("rst_sink_data", bus.sink_data, 32'd0);
        chk("rst_sink_src", 32'(bus.sink_src), 32'd0);
        chk("rst_sink_valid", 32'(bus.sink_valid), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);

        // Round-robin input, first grant after release goes to core 0.
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.src_data = 32'(10 + k);
            in_q.push_back('{rr_exp[k], 32'(10 + k)});
            tick(1);
        end
        bus.src_valid = 1'b0;
        bus.req_in    = '0;
        tick(2);
        chk("in_grant_idle", 32'(bus.in_grant), 32'd0);
        chk("in_data_hold", bus.in_data, 32'd14);

        // Single persistent requester: ready alternates, every other sample.
        bus.req_in    = 4'b0100;
        bus.src_valid = 1'b1;
        bus.src_data  = 32'd100;
        exp_rdy       = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("src_ready_alt", 32'(bus.src_ready), 32'(exp_rdy));
            if (exp_rdy) in_q.push_back('{4'b0100, bus.src_data});
            tick(1);
            if (exp_rdy) bus.src_data = bus.src_data + 32'd1;
            exp_rdy = ~exp_rdy;
        end
        bus.src_valid = 1'b0;
        bus.req_in    = '0;
        tick(2);
        chk("single_all_granted", 32'(in_q.size()), 32'd0);

        // Output drain with backpressure.
        bus.sink_ready = 1'b0;
        set_core(0, -32'sd5);
        set_core(1, 32'd7);
        set_core(3, 32'd9);
        bus.out_en = 4'b1011;
        out_q.push_back('{2'd0, -32'sd5});
        out_q.push_back('{2'd1, 32'd7});
        out_q.push_back('{2'd3, 32'd9});
        tick(1);
        bus.out_en = '0;
        chk("bp_busy_load", 32'(bus.out_busy), 32'b1011);
        chk("bp_valid_lat", 32'(bus.sink_valid), 32'd0);
        tick(1);
        chk("bp_valid_up", 32'(bus.sink_valid), 32'd1);
        chk("bp_busy_after", 32'(bus.out_busy), 32'b1010);
        tick(2);
        chk("bp_stall_data", bus.sink_data, -32'sd5);
        bus.sink_ready = 1'b1;
        tick(1);
        chk("bp_word1", bus.sink_data, 32'd7);
        chk("bp_src1", 32'(bus.sink_src), 32'd1);
        tick(1);
        chk("bp_word2", bus.sink_data, 32'd9);
        chk("bp_src2", 32'(bus.sink_src), 32'd3);
        tick(1);
        chk("bp_valid_down", 32'(bus.sink_valid), 32'd0);
        chk("bp_busy_empty", 32'(bus.out_busy), 32'd0);
        bus.sink_ready = 1'b0;

        // Overflow: park a word in the stalled sink, then double-strobe slot 1.
        set_core(0, 32'd77);
        bus.out_en = 4'b0001;
        out_q.push_back('{2'd0, 32'd77});
        tick(1);
        bus.out_en = '0;
        tick(1);
        set_core(1, 32'd100);
        bus.out_en = 4'b0010;
        out_q.push_back('{2'd1, 32'd100});
        tick(1);
        chk("ovf_first", 32'(bus.ovf), 32'd0);
        set_core(1, 32'd200);
        tick(1);
        bus.out_en = '0;
        chk("ovf_set", 32'(bus.ovf), 32'd1);
        chk("ovf_busy", 32'(bus.out_busy), 32'b0010);
        bus.sink_ready = 1'b1;
        tick(3);
        chk("ovf_drained", 32'(bus.out_busy), 32'd0);
        chk("ovf_sb_empty", 32'(out_q.size()), 32'd0);
        chk("ovf_sticky", 32'(bus.ovf), 32'd1);
        bus.sink_ready = 1'b0;

        // Reset mid-operation discards slots, pending grant and ovf.
        set_core(0, 32'd1);
        set_core(1, 32'd2);
        bus.out_en    = 4'b0011;
        bus.req_in    = 4'b1111;
        bus.src_valid = 1'b1;
        bus.src_data  = 32'd55;
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus.out_en = '0;
        #1;
        chk("mrst_in_grant", 32'(bus.in_grant), 32'd0);
        chk("mrst_out_busy", 32'(bus.out_busy), 32'd0);
        chk("mrst_ovf", 32'(bus.ovf), 32'd0);
        chk("mrst_src_ready", 32'(bus.src_ready), 32'd0);
        tick(1);
        chk("mrst_src_ready_hold", 32'(bus.src_ready), 32'd0);
        chk("mrst_sink_valid", 32'(bus.sink_valid), 32'd0);
        bus.src_valid = 1'b0;
        bus.req_in    = '0;
        rst_n         = 1'b1;
        tick(1);

        // Drain and reload of the same slot in one cycle.
        bus.sink_ready = 1'b1;
        set_core(0, 32'd41);
        bus.out_en = 4'b0001;
        out_q.push_back('{2'd0, 32'd41});
        tick(1);
        set_core(0, 32'd42);
        out_q.push_back('{2'd0, 32'd42});
        tick(1);
        bus.out_en = '0;
        chk("dr_busy0", 32'(bus.out_busy[0]), 32'd1);
        chk("dr_ovf", 32'(bus.ovf), 32'd0);
        chk("dr_first", bus.sink_data, 32'd41);
        tick(1);
        chk("dr_second", bus.sink_data, 32'd42);
        chk("dr_src", 32'(bus.sink_src), 32'd0);
        tick(1);
        chk("dr_valid_down", 32'(bus.sink_valid), 32'd0);
        chk("dr_busy_empty", 32'(bus.out_busy), 32'd0);

        for (int w = 0; w < 20 && (in_q.size() != 0 || out_q.size() != 0); w++) tick(1);
        chk("scoreboard_empty", 32'(in_q.size() + out_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
